// File: rtl/zspan_pkg.sv
// Shared definitions for the z-span fill engine: state encoding,
// depth-test function codes and the default AXI burst length.
package zspan_pkg;

    localparam int BURST_LEN_DEF = 256;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_INIT       = 4'd1,
        ST_LOOP_START = 4'd2,
        ST_LOAD_Z     = 4'd3,
        ST_LOAD_F     = 4'd4,
        ST_INTERP     = 4'd5,
        ST_WR_Z       = 4'd6,
        ST_WR_F       = 4'd7,
        ST_DONE       = 4'd8
    } state_t;

    localparam logic [1:0] ZF_LESS    = 2'd0;
    localparam logic [1:0] ZF_LEQUAL  = 2'd1;
    localparam logic [1:0] ZF_GREATER = 2'd2;
    localparam logic [1:0] ZF_ALWAYS  = 2'd3;

endpackage

// File: rtl/zspan_interp.sv
// Per-pixel datapath: Bresenham-style z step (integer slope plus a
// fractional carry from the error accumulator) and the depth test.
module zspan_interp
    import zspan_pkg::*;
#(
    parameter int Z_W   = 32,
    parameter int CNT_W = 16
) (
    input  logic [Z_W-1:0]   zsum,
    input  logic [CNT_W-1:0] error,
    input  logic [CNT_W-1:0] dx,
    input  logic [CNT_W-1:0] rem,
    input  logic [Z_W-1:0]   slope,
    input  logic [Z_W-1:0]   z_fifo_in,
    input  logic [1:0]       zfunc,
    output logic [Z_W-1:0]   zsum_next,
    output logic [CNT_W-1:0] error_next,
    output logic             pix_pass
);

    localparam logic [Z_W-1:0] Z_ONE = {{(Z_W-1){1'b0}}, 1'b1};

    logic [CNT_W:0] e_sum_s;
    logic           carry_s;
    logic [Z_W-1:0] step_s;
    logic           lt_s;
    logic           eq_s;

    // Error accumulation; a carry bumps the step one unit away from zero.
    always_comb begin
        e_sum_s    = {1'b0, error} + {1'b0, rem};
        carry_s    = (e_sum_s >= {1'b0, dx});
        error_next = e_sum_s[CNT_W-1:0];
        step_s     = slope;
        if (carry_s) begin
            error_next = CNT_W'(e_sum_s - {1'b0, dx});
            if (slope[Z_W-1]) begin
                step_s = slope - Z_ONE;
            end else begin
                step_s = slope + Z_ONE;
            end
        end else begin
            error_next = e_sum_s[CNT_W-1:0];
            step_s     = slope;
        end
        zsum_next = zsum + step_s;
    end

    // Signed depth test of the interpolated z against the stored z.
    always_comb begin
        lt_s     = ($signed(zsum) < $signed(z_fifo_in));
        eq_s     = (zsum == z_fifo_in);
        pix_pass = 1'b0;
        case (zfunc)
            ZF_LESS:    pix_pass = lt_s;
            ZF_LEQUAL:  pix_pass = lt_s | eq_s;
            ZF_GREATER: pix_pass = ~(lt_s | eq_s);
            ZF_ALWAYS:  pix_pass = 1'b1;
            default:    pix_pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/zspan_fsm.sv
// Z-span fill controller: per burst, loads z and colour lines over AXI,
// depth-tests and interpolates one pixel per cycle, then writes both back.
module zspan_fsm
    import zspan_pkg::*;
#(
    parameter int BURST_LEN = BURST_LEN_DEF,
    parameter int Z_W       = 32,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             start,
    input  logic [31:0]      fb_addr,
    input  logic [31:0]      zbuff_addr,
    input  logic [CNT_W-1:0] dx,
    input  logic [Z_W-1:0]   z1,
    input  logic [Z_W-1:0]   slope,
    input  logic [CNT_W-1:0] rem,
    input  logic [CNT_W-1:0] err,
    input  logic [Z_W-1:0]   rgbx,
    input  logic [1:0]       zfunc,
    input  logic             zwrite_en,
    input  logic [Z_W-1:0]   z_fifo_in,
    input  logic [Z_W-1:0]   f_fifo_in,
    input  logic             axi_done,
    output logic             rd_req,
    output logic             wr_req,
    output logic [31:0]      addr,
    output logic [8:0]       beats,
    output logic             axi_bus_to_z_fifo,
    output logic             axi_bus_to_f_fifo,
    output logic             read_in_fifos,
    output logic             write_out_fifos,
    output logic             read_z_out_fifo,
    output logic             read_f_out_fifo,
    output logic [Z_W-1:0]   z_out,
    output logic [Z_W-1:0]   f_out,
    output logic             pix_we,
    output logic             done,
    output logic             busy,
    output logic [Z_W-1:0]   z_sum_out,
    output logic [3:0]       curr_state
);

    state_t           state_r;
    logic [CNT_W-1:0] remain_r;
    logic [Z_W-1:0]   zsum_r;
    logic [CNT_W-1:0] error_r;
    logic [31:0]      offset_r;
    logic [8:0]       beats_r;
    logic [8:0]       cnt_r;

    logic [8:0]       burst_len_s;
    logic             last_s;
    logic [Z_W-1:0]   zsum_next_s;
    logic [CNT_W-1:0] error_next_s;
    logic             pass_s;

    zspan_interp #(
        .Z_W   (Z_W),
        .CNT_W (CNT_W)
    ) u_interp (
        .zsum       (zsum_r),
        .error      (error_r),
        .dx         (dx),
        .rem        (rem),
        .slope      (slope),
        .z_fifo_in  (z_fifo_in),
        .zfunc      (zfunc),
        .zsum_next  (zsum_next_s),
        .error_next (error_next_s),
        .pix_pass   (pass_s)
    );

    // Next burst length: full bursts until the tail, then the exact remainder.
    always_comb begin
        if (remain_r > CNT_W'(BURST_LEN)) begin
            burst_len_s = 9'(BURST_LEN);
        end else begin
            burst_len_s = 9'(remain_r);
        end
        last_s = ((cnt_r + 9'd1) == beats_r);
    end

    // Span sequencer: burst bookkeeping, beat counting and z/error state.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_r  <= ST_IDLE;
            remain_r <= '0;
            zsum_r   <= '0;
            error_r  <= '0;
            offset_r <= 32'd0;
            beats_r  <= 9'd0;
            cnt_r    <= 9'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    remain_r <= dx;
                    zsum_r   <= z1;
                    error_r  <= err;
                    offset_r <= 32'd0;
                    cnt_r    <= 9'd0;
                    state_r  <= ST_LOOP_START;
                end
                ST_LOOP_START: begin
                    if (remain_r == '0) begin
                        state_r <= ST_DONE;
                    end else begin
                        beats_r  <= burst_len_s;
                        remain_r <= remain_r - CNT_W'(burst_len_s);
                        cnt_r    <= 9'd0;
                        state_r  <= ST_LOAD_Z;
                    end
                end
                ST_LOAD_Z, ST_LOAD_F, ST_WR_Z, ST_WR_F: begin
                    if (axi_done) begin
                        if (last_s) begin
                            cnt_r <= 9'd0;
                            case (state_r)
                                ST_LOAD_Z: state_r <= ST_LOAD_F;
                                ST_LOAD_F: state_r <= ST_INTERP;
                                ST_WR_Z:   state_r <= ST_WR_F;
                                default: begin
                                    offset_r <= offset_r + {21'd0, beats_r, 2'b00};
                                    state_r  <= ST_LOOP_START;
                                end
                            endcase
                        end else begin
                            cnt_r <= cnt_r + 9'd1;
                        end
                    end
                end
                ST_INTERP: begin
                    zsum_r  <= zsum_next_s;
                    error_r <= error_next_s;
                    if (last_s) begin
                        cnt_r   <= 9'd0;
                        state_r <= zwrite_en ? ST_WR_Z : ST_WR_F;
                    end else begin
                        cnt_r <= cnt_r + 9'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus/fifo strobes and pixel outputs decoded from state; all forced low in reset.
    always_comb begin
        rd_req            = 1'b0;
        wr_req            = 1'b0;
        addr              = 32'd0;
        axi_bus_to_z_fifo = 1'b0;
        axi_bus_to_f_fifo = 1'b0;
        read_in_fifos     = 1'b0;
        write_out_fifos   = 1'b0;
        read_z_out_fifo   = 1'b0;
        read_f_out_fifo   = 1'b0;
        done              = 1'b0;
        busy              = 1'b0;
        pix_we            = 1'b0;
        z_out             = '0;
        f_out             = '0;
        if (nreset) begin
            busy   = (state_r != ST_IDLE) && (state_r != ST_DONE);
            pix_we = pass_s;
            z_out  = (pass_s && zwrite_en) ? zsum_r : z_fifo_in;
            f_out  = pass_s ? rgbx : f_fifo_in;
            case (state_r)
                ST_LOAD_Z: begin
                    rd_req            = ~axi_done;
                    axi_bus_to_z_fifo = axi_done;
                    addr              = zbuff_addr + offset_r;
                end
                ST_LOAD_F: begin
                    rd_req            = ~axi_done;
                    axi_bus_to_f_fifo = axi_done;
                    addr              = fb_addr + offset_r;
                end
                ST_INTERP: begin
                    read_in_fifos   = 1'b1;
                    write_out_fifos = 1'b1;
                    read_z_out_fifo = ~zwrite_en;
                end
                ST_WR_Z: begin
                    wr_req          = ~axi_done;
                    read_z_out_fifo = axi_done;
                    addr            = zbuff_addr + offset_r;
                end
                ST_WR_F: begin
                    wr_req          = ~axi_done;
                    read_f_out_fifo = axi_done;
                    addr            = fb_addr + offset_r;
                end
                ST_DONE: begin
                    done = 1'b1;
                end
                default: begin
                    done = 1'b0;
                end
            endcase
        end else begin
            busy = 1'b0;
        end
    end

    assign beats      = beats_r;
    assign z_sum_out  = zsum_r;
    assign curr_state = state_r;

endmodule
